// File: rtl/array_stream_checker_if.sv
// Beat-serial element stream: valid/ready handshake carrying one W-bit element
// per transfer, with in_last marking the final beat of a frame.
interface array_stream_checker_if #(
  parameter int W = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/array_stream_checker.sv
// Collects an N-element beat stream into an array, then compares it once against
// EXPECTED and holds the verdict until acknowledged.
module array_stream_checker #(
  parameter int W = 4,
  parameter int N = 8,
  parameter logic [W-1:0] EXPECTED [N-1:0] =
    '{W'(7), W'(6), W'(5), W'(4), W'(3), W'(2), W'(1), W'(0)}
) (
  input  logic                     clk,
  input  logic                     reset_l,
  array_stream_checker_if.slave    strm,
  input  logic                     ack,
  output logic [W-1:0]             arr_out [N-1:0],
  output logic                     done,
  output logic                     match,
  output logic                     frame_err,
  output logic [$clog2(N+1)-1:0]   err_count,
  output logic [$clog2(N)-1:0]     first_bad
);
  localparam int CW = $clog2(N+1);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N-1);

  localparam logic [1:0] S_RECV  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  arr_q [N-1:0];
  logic [W-1:0]  arr_d [N-1:0];
  logic          done_q, done_d;
  logic          match_q, match_d;
  logic          frame_err_q, frame_err_d;
  logic [CW-1:0] err_count_q, err_count_d;
  logic [IW-1:0] first_bad_q, first_bad_d;
  logic          in_ready_q, in_ready_d;
  logic          xfer;
  logic [CW-1:0] mis_cnt;
  logic [IW-1:0] mis_first;

  // Scanning downward leaves the lowest mismatching index in mis_first.
  always_comb begin
    mis_cnt   = '0;
    mis_first = '0;
    for (int i = N-1; i >= 0; i--) begin
      if (arr_q[i] != EXPECTED[i]) begin
        mis_cnt   = mis_cnt + CW'(1);
        mis_first = IW'(i);
      end
    end
  end

  assign xfer = strm.in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    arr_d       = arr_q;
    done_d      = done_q;
    match_d     = match_q;
    frame_err_d = frame_err_q;
    err_count_d = err_count_q;
    first_bad_d = first_bad_q;
    case (state_q)
      S_RECV: begin
        if (xfer) begin
          arr_d[idx_q] = strm.in_data;
          if (idx_q == IDX_LAST) begin
            frame_err_d = !strm.in_last;
            state_d     = S_CHECK;
          end else if (strm.in_last) begin
            frame_err_d = 1'b1;
            state_d     = S_CHECK;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      S_CHECK: begin
        err_count_d = mis_cnt;
        first_bad_d = mis_first;
        match_d     = (mis_cnt == '0) && !frame_err_q;
        done_d      = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (ack) begin
          done_d      = 1'b0;
          frame_err_d = 1'b0;
          idx_d       = '0;
          state_d     = S_RECV;
        end
      end
      default: state_d = S_RECV;
    endcase
    // Ready is registered from the next state so it never depends on in_* combinationally.
    in_ready_d = (state_d == S_RECV);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q     <= S_RECV;
      idx_q       <= '0;
      for (int i = 0; i < N; i++) arr_q[i] <= '0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
      first_bad_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      arr_q       <= arr_d;
      done_q      <= done_d;
      match_q     <= match_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
      first_bad_q <= first_bad_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign strm.in_ready = in_ready_q;
  assign arr_out       = arr_q;
  assign done          = done_q;
  assign match         = match_q;
  assign frame_err     = frame_err_q;
  assign err_count     = err_count_q;
  assign first_bad     = first_bad_q;
endmodule

// File: tb/tb_array_stream_checker.sv
// Scoreboard bench: the driver pushes the expected verdict of each frame, a
// negedge monitor pops it when done rises and compares.
module tb_array_stream_checker;
  localparam int W  = 4;
  localparam int N  = 8;
  localparam int CW = $clog2(N+1);
  localparam int IW = $clog2(N);

  typedef struct packed {
    logic [N*W-1:0] arr;
    logic           match;
    logic           ferr;
    logic [CW-1:0]  ec;
    logic [IW-1:0]  fb;
  } exp_t;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  logic ack = 1'b0;
  logic [W-1:0]  arr_out [N-1:0];
  logic          done, match, frame_err;
  logic [CW-1:0] err_count;
  logic [IW-1:0] first_bad;

  array_stream_checker_if #(.W(W)) bus();

  array_stream_checker #(.W(W), .N(N)) dut (
    .clk(clk), .reset_l(reset_l), .strm(bus), .ack(ack), .arr_out(arr_out),
    .done(done), .match(match), .frame_err(frame_err),
    .err_count(err_count), .first_bad(first_bad)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  exp_t sbq[$];
  logic [W-1:0] model_arr [N];
  logic [W-1:0] beats[$];
  logic done_prev = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [N*W-1:0] pack_dut();
    logic [N*W-1:0] p;
    for (int i = 0; i < N; i++) p[i*W +: W] = arr_out[i];
    return p;
  endfunction

  function automatic logic [N*W-1:0] pack_model();
    logic [N*W-1:0] p;
    for (int i = 0; i < N; i++) p[i*W +: W] = model_arr[i];
    return p;
  endfunction

  // Reference: the frame overwrites the leading entries, then is judged against element[i] == i.
  task automatic model_frame(input bit ferr);
    exp_t e;
    int   ec;
    int   fb;
    ec = 0;
    fb = -1;
    for (int k = 0; k < beats.size(); k++) model_arr[k] = beats[k];
    for (int i = 0; i < N; i++) begin
      if (int'(model_arr[i]) != i) begin
        ec++;
        if (fb < 0) fb = i;
      end
    end
    e.arr   = pack_model();
    e.ferr  = ferr;
    e.ec    = CW'(ec);
    e.fb    = (fb < 0) ? '0 : IW'(fb);
    e.match = (ec == 0) && !ferr;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("match", match, e.match);
        chk("frame_err", frame_err, e.ferr);
        chk("err_count", err_count, e.ec);
        chk("first_bad", first_bad, e.fb);
        chk("arr_out", pack_dut(), e.arr);
      end
    end
    done_prev <= done;
  end

  task automatic do_reset();
    #2 reset_l = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    ack = 1'b0;
    #1;
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_match", match, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_first_bad", first_bad, 0);
    chk("rst_arr_out", pack_dut(), 0);
    for (int i = 0; i < N; i++) model_arr[i] = '0;
    sbq.delete();
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  // Drives the beats queue; the beat is presented at a negedge and transfers at the next posedge.
  task automatic drive_beats(input bit with_last, input bit gaps);
    for (int k = 0; k < beats.size(); k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
          bus.in_data  = W'($urandom);
        end
      end
      @(negedge clk);
      chk("ready_in_frame", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = beats[k];
      bus.in_last  = with_last && (k == beats.size() - 1);
    end
  endtask

  task automatic finish_frame(input bit ferr, input bit hold);
    model_frame(ferr);
    @(negedge clk);
    bus.in_valid = hold;
    bus.in_data  = W'($urandom);
    bus.in_last  = 1'(($urandom));
    chk("check_done_low", done, 0);
    chk("check_ready_low", bus.in_ready, 0);
    @(negedge clk);
    chk("latency_done", done, 1);
    chk("done_ready_low", bus.in_ready, 0);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      bus.in_data = W'($urandom);
      chk("done_hold", done, 1);
      chk("done_ready_low", bus.in_ready, 0);
    end
    chk("done_arr_stable", pack_dut(), pack_model());
    ack = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_done_low", done, 0);
    chk("ack_frame_err_low", frame_err, 0);
    chk("ack_ready_high", bus.in_ready, 1);
  endtask

  task automatic run_frame(input bit with_last, input bit gaps, input bit hold);
    bit ferr;
    ferr = with_last ? (beats.size() != N) : 1'b1;
    drive_beats(with_last, gaps);
    finish_frame(ferr, hold);
  endtask

  task automatic load_seq();
    beats.delete();
    for (int i = 0; i < N; i++) beats.push_back(W'(i));
  endtask

  initial begin
    int kind;
    int len;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    @(negedge clk);
    do_reset();

    load_seq();
    run_frame(1'b1, 1'b0, 1'b0);

    beats = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd4, 4'd5, 4'd6, 4'd15};
    run_frame(1'b1, 1'b0, 1'b0);
    load_seq();
    run_frame(1'b1, 1'b0, 1'b0);

    do_reset();
    beats = '{4'd0, 4'd1, 4'd2};
    run_frame(1'b1, 1'b0, 1'b0);

    load_seq();
    run_frame(1'b0, 1'b0, 1'b0);

    load_seq();
    run_frame(1'b1, 1'b1, 1'b1);

    beats = '{4'd5, 4'd5, 4'd5, 4'd5};
    drive_beats(1'b0, 1'b0);
    @(negedge clk);
    do_reset();
    load_seq();
    run_frame(1'b1, 1'b0, 1'b0);

    for (int f = 0; f < 24; f++) begin
      kind = $urandom_range(0, 3);
      beats.delete();
      case (kind)
        0: load_seq();
        1: begin
          load_seq();
          for (int i = 0; i < N; i++)
            if ($urandom_range(0, 9) < 3) beats[i] = W'($urandom);
        end
        2: begin
          len = $urandom_range(1, N-1);
          for (int i = 0; i < len; i++) beats.push_back(W'($urandom));
        end
        default: for (int i = 0; i < N; i++) beats.push_back(W'($urandom));
      endcase
      run_frame(kind != 3, 1'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
